// File: rtl/cva5_config.sv
`default_nettype none
// ============================================================================
//  Module      : cva5_config (package)
//  Description : Shared configuration helpers. lvt_width() sizes a live value
//                table entry so it can name any of n write ports, with a
//                minimum of one bit so a single-port table stays well formed.
//  Revision    : 1.0  initial release
// ============================================================================
package cva5_config;

  function automatic int lvt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/live_value_table.sv
`default_nettype none
// ============================================================================
//  Module      : live_value_table
//  Description : Per-address record of which write bank holds the live value.
//                Asynchronously reset to bank 0. When several ports write the
//                same address in one cycle, the highest-indexed port wins.
//  Ports       : clk, rst     - clock, async active-high reset
//                waddr[]      - write addresses, one per write port
//                write_en[]   - accepted writes, one per write port
//                raddr[]      - read addresses, one per read port
//                bank_sel[]   - bank holding the live value for each read port
//  Revision    : 1.0  initial release
// ============================================================================
module live_value_table
  import cva5_config::*;
#(
  parameter int DEPTH           = 32,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int NUM_READ_PORTS  = 2,
  localparam int LVT_W          = lvt_width(NUM_WRITE_PORTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] waddr    [NUM_WRITE_PORTS],
  input  logic                     write_en [NUM_WRITE_PORTS],
  input  logic [$clog2(DEPTH)-1:0] raddr    [NUM_READ_PORTS],
  output logic [LVT_W-1:0]         bank_sel [NUM_READ_PORTS]
);

  logic [LVT_W-1:0] r_lvt [DEPTH];

  // Ports are visited in ascending order, so the last non-blocking
  // assignment to a shared address (the highest port) is the one that sticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < DEPTH; a++)
        r_lvt[a] <= '0;
    end else begin
      for (int b = 0; b < NUM_WRITE_PORTS; b++)
        if (write_en[b])
          r_lvt[waddr[b]] <= LVT_W'(b);
    end
  end

  generate
    for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_sel
      assign bank_sel[i] = r_lvt[raddr[i]];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/lutram_1w_mr.sv
`default_nettype none
// ============================================================================
//  Module      : lutram_1w_mr
//  Description : One-write, multi-read distributed RAM. Synchronous write,
//                asynchronous reads. Contents are not reset.
//  Ports       : clk          - clock
//                waddr        - write address
//                ram_write    - write enable
//                new_ram_data - write data
//                raddr[]      - read addresses, one per read port
//                ram_data_out[] - combinational read data, one per read port
//  Revision    : 1.0  initial release
// ============================================================================
module lutram_1w_mr #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 32,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic                     ram_write,
  input  logic [WIDTH-1:0]         new_ram_data,
  input  logic [$clog2(DEPTH)-1:0] raddr        [NUM_READ_PORTS],
  output logic [WIDTH-1:0]         ram_data_out [NUM_READ_PORTS]
);

  logic [WIDTH-1:0] r_ram [DEPTH];

  always_ff @(posedge clk) begin
    if (ram_write)
      r_ram[waddr] <= new_ram_data;
  end

  generate
    for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_read
      assign ram_data_out[i] = r_ram[raddr[i]];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/lutram_mw_mr.sv
`default_nettype none
// ============================================================================
//  Module      : lutram_mw_mr
//  Description : Multi-write, multi-read LUTRAM. One replicated bank per write
//                port plus a live value table selecting the bank with the
//                newest data. After reset a sweep zeroes bank 0 so every entry
//                reads 0 until written; ready flags the end of the sweep.
//  Ports       : clk, rst       - clock, async active-high reset
//                waddr[]        - write addresses, one per write port
//                ram_write[]    - write enables (ignored while ready = 0)
//                new_ram_data[] - write data
//                raddr[]        - read addresses, one per read port
//                ram_data_out[] - combinational read data (0 while ready = 0)
//                ready          - initialisation complete
//  Revision    : 1.0  initial release
// ============================================================================
module lutram_mw_mr
  import cva5_config::*;
#(
  parameter int WIDTH           = 32,
  parameter int DEPTH           = 32,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int NUM_READ_PORTS  = 2,
  parameter int WRITE_BYPASS    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] waddr        [NUM_WRITE_PORTS],
  input  logic                     ram_write    [NUM_WRITE_PORTS],
  input  logic [WIDTH-1:0]         new_ram_data [NUM_WRITE_PORTS],
  input  logic [$clog2(DEPTH)-1:0] raddr        [NUM_READ_PORTS],
  output logic [WIDTH-1:0]         ram_data_out [NUM_READ_PORTS],
  output logic                     ready
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVT_W  = lvt_width(NUM_WRITE_PORTS);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } init_state_t;

  init_state_t       r_state;
  logic [ADDR_W-1:0] r_init_addr;
  logic              r_ready;

  logic              w_accept     [NUM_WRITE_PORTS];
  logic              w_bank_we    [NUM_WRITE_PORTS];
  logic [ADDR_W-1:0] w_bank_waddr [NUM_WRITE_PORTS];
  logic [WIDTH-1:0]  w_bank_wdata [NUM_WRITE_PORTS];
  logic [WIDTH-1:0]  w_bank_rdata [NUM_WRITE_PORTS][NUM_READ_PORTS];
  logic [LVT_W-1:0]  w_sel        [NUM_READ_PORTS];

  // Init sweep: one entry of bank 0 per cycle, RUN after the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= INIT;
      r_init_addr <= '0;
      r_ready     <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_init_addr <= r_init_addr + 1'b1;
          if (r_init_addr == c_LAST_ADDR) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= RUN;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready = r_ready;

  // External writes only count once ready; bank 0 is owned by the sweep
  // until then.
  always_comb begin
    for (int b = 0; b < NUM_WRITE_PORTS; b++) begin
      w_accept[b]     = ram_write[b] & r_ready;
      w_bank_we[b]    = w_accept[b];
      w_bank_waddr[b] = waddr[b];
      w_bank_wdata[b] = new_ram_data[b];
    end
    if (!r_ready) begin
      w_bank_we[0]    = 1'b1;
      w_bank_waddr[0] = r_init_addr;
      w_bank_wdata[0] = '0;
    end
  end

  generate
    for (genvar b = 0; b < NUM_WRITE_PORTS; b++) begin : g_bank
      lutram_1w_mr #(
        .WIDTH          (WIDTH),
        .DEPTH          (DEPTH),
        .NUM_READ_PORTS (NUM_READ_PORTS)
      ) u_bank (
        .clk          (clk),
        .waddr        (w_bank_waddr[b]),
        .ram_write    (w_bank_we[b]),
        .new_ram_data (w_bank_wdata[b]),
        .raddr        (raddr),
        .ram_data_out (w_bank_rdata[b])
      );
    end
  endgenerate

  live_value_table #(
    .DEPTH           (DEPTH),
    .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
    .NUM_READ_PORTS  (NUM_READ_PORTS)
  ) u_lvt (
    .clk      (clk),
    .rst      (rst),
    .waddr    (waddr),
    .write_en (w_accept),
    .raddr    (raddr),
    .bank_sel (w_sel)
  );

  // Read path: LVT-selected bank, optionally overridden by a same-cycle write
  // (highest matching port wins, same priority as the LVT), forced to 0
  // until the sweep completes.
  always_comb begin
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      ram_data_out[i] = w_bank_rdata[w_sel[i]][i];
      if (WRITE_BYPASS != 0) begin
        for (int b = 0; b < NUM_WRITE_PORTS; b++)
          if (w_accept[b] && (waddr[b] == raddr[i]))
            ram_data_out[i] = new_ram_data[b];
      end
      if (!r_ready)
        ram_data_out[i] = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lutram_mw_mr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lutram_mw_mr
//  Description : Self-checking bench for lutram_mw_mr. Two instances share all
//                inputs: one without write bypass, one with it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lutram_mw_mr;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] waddr [2];
  logic          wen   [2];
  logic [W-1:0]  wdata [2];
  logic [AW-1:0] raddr [2];
  logic [W-1:0]  rdo0  [2];
  logic [W-1:0]  rdo1  [2];
  logic          rdy0, rdy1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lutram_mw_mr #(.WIDTH(W), .DEPTH(D), .NUM_WRITE_PORTS(2), .NUM_READ_PORTS(2), .WRITE_BYPASS(0)) u_dut0 (
    .clk(clk), .rst(rst), .waddr(waddr), .ram_write(wen), .new_ram_data(wdata),
    .raddr(raddr), .ram_data_out(rdo0), .ready(rdy0)
  );

  lutram_mw_mr #(.WIDTH(W), .DEPTH(D), .NUM_WRITE_PORTS(2), .NUM_READ_PORTS(2), .WRITE_BYPASS(1)) u_dut1 (
    .clk(clk), .rst(rst), .waddr(waddr), .ram_write(wen), .new_ram_data(wdata),
    .raddr(raddr), .ram_data_out(rdo1), .ready(rdy1)
  );

  typedef struct {
    logic          we0, we1;
    logic [AW-1:0] wa0, wa1;
    logic [W-1:0]  wd0, wd1;
    logic [AW-1:0] ra0, ra1;
    logic [W-1:0]  e0_0, e0_1;  // expected, no bypass
    logic [W-1:0]  e1_0, e1_1;  // expected, bypass
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_w(input logic e0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                       input logic e1, input logic [AW-1:0] a1, input logic [W-1:0] d1);
    wen[0] = e0; waddr[0] = a0; wdata[0] = d0;
    wen[1] = e1; waddr[1] = a1; wdata[1] = d1;
  endtask

  task automatic vec(input int k, input logic we0, input logic [AW-1:0] wa0, input logic [W-1:0] wd0,
                     input logic we1, input logic [AW-1:0] wa1, input logic [W-1:0] wd1,
                     input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                     input logic [W-1:0] e00, input logic [W-1:0] e01,
                     input logic [W-1:0] e10, input logic [W-1:0] e11);
    vecs[k] = '{we0, we1, wa0, wa1, wd0, wd1, ra0, ra1, e00, e01, e10, e11};
  endtask

  initial begin
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    raddr[0] = 5'd2; raddr[1] = 5'd2;

    //            we0 wa0 wd0            we1 wa1 wd1            ra0 ra1 nobypass exp            bypass exp
    vec(0,  1, 3,  32'hAAAA5555, 1, 7,  32'h12345678, 3,  7,  32'h0,        32'h0,        32'hAAAA5555, 32'h12345678);
    vec(1,  0, 0,  32'h0,        0, 0,  32'h0,        3,  7,  32'hAAAA5555, 32'h12345678, 32'hAAAA5555, 32'h12345678);
    vec(2,  1, 5,  32'h1,        1, 5,  32'h2,        5,  5,  32'h0,        32'h0,        32'h2,        32'h2);
    vec(3,  0, 0,  32'h0,        0, 0,  32'h0,        5,  5,  32'h2,        32'h2,        32'h2,        32'h2);
    vec(4,  1, 5,  32'h3,        0, 0,  32'h0,        5,  3,  32'h2,        32'hAAAA5555, 32'h3,        32'hAAAA5555);
    vec(5,  0, 0,  32'h0,        0, 0,  32'h0,        5,  7,  32'h3,        32'h12345678, 32'h3,        32'h12345678);
    vec(6,  0, 0,  32'h0,        1, 9,  32'hDEAD,     9,  5,  32'h0,        32'h3,        32'hDEAD,     32'h3);
    vec(7,  0, 0,  32'h0,        0, 0,  32'h0,        9,  9,  32'hDEAD,     32'hDEAD,     32'hDEAD,     32'hDEAD);
    vec(8,  1, 9,  32'h5,        1, 3,  32'h6,        9,  3,  32'hDEAD,     32'hAAAA5555, 32'h5,        32'h6);
    vec(9,  0, 0,  32'h0,        0, 0,  32'h0,        9,  3,  32'h5,        32'h6,        32'h5,        32'h6);
    vec(10, 1, 31, 32'h1234,     1, 0,  32'hFFFFFFFF, 31, 0,  32'h0,        32'h0,        32'h1234,     32'hFFFFFFFF);
    vec(11, 0, 0,  32'h0,        0, 0,  32'h0,        0,  31, 32'hFFFFFFFF, 32'h1234,     32'hFFFFFFFF, 32'h1234);
    vec(12, 1, 0,  32'h7,        0, 0,  32'h0,        0,  2,  32'hFFFFFFFF, 32'h0,        32'h7,        32'h0);
    vec(13, 0, 0,  32'h0,        0, 0,  32'h0,        0,  0,  32'h7,        32'h7,        32'h7,        32'h7);

    // Reset state
    #2;
    chk("reset_ready0", {31'b0, rdy0}, 32'h0);
    chk("reset_ready1", {31'b0, rdy1}, 32'h0);
    chk("reset_out0", rdo0[0], 32'h0);
    chk("reset_out1", rdo1[1], 32'h0);

    // Init sweep with writes to address 2 held throughout, including the
    // last INIT cycle; all must be dropped.
    set_w(1'b1, 5'd2, 32'hFFFF, 1'b1, 5'd2, 32'hFFFF);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= D; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sweep_ready_c%0d", c), {31'b0, rdy0}, {31'b0, (c == D)});
      chk($sformatf("sweep_ready_byp_c%0d", c), {31'b0, rdy1}, {31'b0, (c == D)});
      if (c < D) chk($sformatf("sweep_out_c%0d", c), rdo1[0], 32'h0);
    end
    set_w(1'b0, '0, '0, 1'b0, '0, '0);

    // Every address reads zero on every port of both instances
    for (int a = 0; a < D; a++) begin
      @(negedge clk);
      raddr[0] = AW'(a); raddr[1] = AW'(D - 1 - a);
      #1;
      chk($sformatf("zero_a%0d", a),
          rdo0[0] | rdo0[1] | rdo1[0] | rdo1[1], 32'h0);
    end

    // Table-driven vectors: inputs at negedge, outputs checked before posedge
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      set_w(vecs[k].we0, vecs[k].wa0, vecs[k].wd0, vecs[k].we1, vecs[k].wa1, vecs[k].wd1);
      raddr[0] = vecs[k].ra0; raddr[1] = vecs[k].ra1;
      #1;
      chk($sformatf("vec%0d_nobyp_p0", k), rdo0[0], vecs[k].e0_0);
      chk($sformatf("vec%0d_nobyp_p1", k), rdo0[1], vecs[k].e0_1);
      chk($sformatf("vec%0d_byp_p0", k),   rdo1[0], vecs[k].e1_0);
      chk($sformatf("vec%0d_byp_p1", k),   rdo1[1], vecs[k].e1_1);
    end

    // Reset mid-RUN: write BEEF to address 4, then async reset between edges
    @(negedge clk);
    set_w(1'b0, '0, '0, 1'b1, 5'd4, 32'hBEEF);
    raddr[0] = 5'd4; raddr[1] = 5'd4;
    @(negedge clk);
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    chk("beef_written", rdo0[0], 32'hBEEF);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'b0, rdy0}, 32'h0);
    chk("midrst_out0", rdo0[0], 32'h0);
    chk("midrst_out1", rdo1[1], 32'h0);
    #1;
    rst = 1'b0;
    begin
      int c;
      c = 0;
      while (!rdy0 && c < D + 4) begin
        @(posedge clk);
        #1;
        c++;
      end
      chk("midrst_sweep_len", 32'(c), 32'(D));
    end
    // First cycle with ready: address 4 reads zero, and a write presented
    // in this very cycle is accepted.
    chk("midrst_a4_zero0", rdo0[0], 32'h0);
    chk("midrst_a4_zero1", rdo0[1], 32'h0);
    set_w(1'b1, 5'd4, 32'h55, 1'b0, '0, '0);
    #1;
    chk("ready_cycle_bypass", rdo1[0], 32'h55);
    chk("ready_cycle_nobyp", rdo0[0], 32'h0);
    @(posedge clk);
    #1;
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    chk("ready_cycle_write", rdo0[0], 32'h55);
    chk("ready_cycle_write_byp", rdo1[1], 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lutram_mw_mr.md
# lutram_mw_mr

Multi-write, multi-read LUTRAM built from `NUM_WRITE_PORTS` replicated banks and a live value table (LVT). The LVT records, for each address, which bank holds the current value. The block also runs an automatic zero-initialisation sweep after reset, so every entry reads as 0 until it is written. It is intended for register files and tag stores that receive several writebacks per cycle.

## Interface
Parameters:
- `WIDTH`, 32: data bits per entry
- `DEPTH`, 32: number of entries; power of two, ≥2
- `NUM_WRITE_PORTS`, 2: write ports, ≥1
- `NUM_READ_PORTS`, 2: read ports, ≥1
- `WRITE_BYPASS`, 0: 1 = same-cycle write-to-read forwarding; 0 = new data is visible in the cycle after the write

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `waddr`  in  `[NUM_WRITE_PORTS]` × `$clog2(DEPTH)`  write addresses
- `ram_write`  in  `[NUM_WRITE_PORTS]` × 1  per-port write enable
- `new_ram_data`  in  `[NUM_WRITE_PORTS]` × `WIDTH`  write data
- `raddr`  in  `[NUM_READ_PORTS]` × `$clog2(DEPTH)`  read addresses
- `ram_data_out`  out  `[NUM_READ_PORTS]` × `WIDTH`  read data, combinational from `raddr`
- `ready`  out  1  initialisation complete; external writes are accepted only while this is 1

## Operation
- Storage: bank `b` holds the writes from port `b`. Bank `b` is a 1-write/`NUM_READ_PORTS`-read LUTRAM.
- LVT: `DEPTH` × `LVT_W` flops, where `LVT_W = max(1, $clog2(NUM_WRITE_PORTS))`. The LVT is asynchronously reset to 0.
  - On an accepted write on port `b`, `lvt[waddr[b]] <= b`.
- Read: `ram_data_out[i] = bank[lvt[raddr[i]]].read[i]`.
- Same-address write conflict in one cycle: the highest-indexed writing port wins.
  - Its index goes into the LVT.
  - The losing banks are still written. This is harmless because the LVT does not select them.
- FSM has two states, INIT and RUN.
  - INIT (entered on `rst`):
    - The counter `init_addr` starts at 0.
    - Each cycle, bank 0 is written with 0 at `init_addr`, via a mux ahead of bank 0's write port.
    - `init_addr` then increments.
    - When `init_addr == DEPTH-1` is written, the FSM moves to RUN.
  - RUN: normal operation; `ready = 1`.
- During INIT:
  - `ram_write` is ignored on all ports, with no bank or LVT update.
  - `ram_data_out` is forced to 0.
- `WRITE_BYPASS = 1`, in RUN:
  - If any `ram_write[b]` has `waddr[b] == raddr[i]`, `ram_data_out[i]` returns `new_ram_data` of the highest such `b`.
  - Otherwise it returns the normal read.
- `NUM_WRITE_PORTS == 1`: degenerates to a single bank; the LVT is constant 0 and may be optimised away.

## Timing
- Reset values:
  - `ready = 0`, state INIT, `init_addr = 0`, LVT all 0.
  - `ram_data_out = 0` while in INIT.
- Init duration: exactly `DEPTH` clock edges after `rst` deasserts. `ready` rises after edge `DEPTH`.
- Write latency:
  - Data written at edge N is visible combinationally after edge N.
  - With `WRITE_BYPASS = 1`, the data is also visible before edge N.
- Read latency: 0 cycles (asynchronous read).
- `rst` asserted mid-INIT or mid-RUN:
  - Immediately returns to INIT with `init_addr = 0`, LVT all 0, `ready = 0`.
  - The sweep restarts from 0 after deassert.
- A write presented in the cycle `ready` rises is accepted. A write presented in the last INIT cycle is dropped.

## Structure
- Shared package `cva5_config` gets a `function lvt_width(int n)` returning `max(1, $clog2(n))`.
- Local typedef `init_state_t` with values {INIT, RUN}.
- Bank 0 write mux and FSM/counter are inline.
- Banks reuse the existing 1-write/multi-read LUTRAM module (one instance per write port), which keeps vendor-specific inference in one place.
- One natural new sub-module: `live_value_table`, with parameters `DEPTH`, `NUM_WRITE_PORTS`, `NUM_READ_PORTS`. It holds the async-reset flops, the write priority logic and the read muxing.

## Test plan
- Init sweep (`DEPTH = 32`):
  - Release `rst`; `ready` is 0 for 32 cycles and 1 on cycle 33.
  - All 32 addresses then read 0 on every read port.
- Two-port write, distinct addresses:
  - `waddr = {3, 7}`, data `{0xAAAA5555, 0x12345678}`.
  - Next cycle, `raddr = {3, 7}` returns `{0xAAAA5555, 0x12345678}`.
- Conflict:
  - Both ports write address 5, data `{0x1, 0x2}`.
  - Next cycle, address 5 reads 0x2 on all read ports.
  - A later write of 0x3 on port 0 alone makes address 5 read 0x3.
- Bypass (`WRITE_BYPASS = 1`):
  - Port 1 writes 0xDEAD to address 9 while read port 0 reads 9; the same cycle returns 0xDEAD.
  - With `WRITE_BYPASS = 0`, that cycle returns the old value 0.
- Writes during INIT:
  - Assert `ram_write` with 0xFFFF on address 2 during the sweep.
  - After `ready`, address 2 reads 0.
- Reset mid-RUN:
  - Write 0xBEEF to address 4, then pulse `rst` asynchronously between edges.
  - `ready` drops immediately and the outputs read 0.
  - After the 32-cycle sweep, address 4 reads 0.
